// File: rtl/demux3_buf_pkg.sv
// Shared constants for the 1-to-3 registered demultiplexer: default word width
// and the destination select encoding.
package demux3_buf_pkg;

    localparam int DEF_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_C    = 2'b10,
        SEL_DROP = 2'b11
    } sel_e;

endpackage

// File: rtl/demux3_buf_slot_reg.sv
// One-entry output buffer. It can be drained and refilled in the same cycle,
// so a consumer holding ready gets one word per cycle.
module slot_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && pop_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset as well, because the output word must read zero out of reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign free  = !valid_q || pop_ready;

endmodule

// File: rtl/demux3_buf.sv
// Registered 1-to-3 demultiplexer: select decode, in_ready mux and drop
// accounting around three independent one-entry slots.
module demux3_buf
    import demux3_buf_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    output logic                  out_valid_a,
    output logic                  out_valid_b,
    output logic                  out_valid_c,
    input  logic                  out_ready_a,
    input  logic                  out_ready_b,
    input  logic                  out_ready_c,
    output logic [WORD_WIDTH-1:0] out_data_a,
    output logic [WORD_WIDTH-1:0] out_data_b,
    output logic [WORD_WIDTH-1:0] out_data_c,
    output logic                  drop_err,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    logic free_a, free_b, free_c;
    logic accept;
    logic load_a, load_b, load_c, drop_accept;

    logic                 drop_err_q,   drop_err_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    // in_ready depends only on the select and slot state, never on in_data.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            SEL_A:    in_ready = free_a;
            SEL_B:    in_ready = free_b;
            SEL_C:    in_ready = free_c;
            SEL_DROP: in_ready = 1'b1;
            default:  in_ready = 1'b1;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign load_a      = accept && (in_sel == SEL_A);
    assign load_b      = accept && (in_sel == SEL_B);
    assign load_c      = accept && (in_sel == SEL_C);
    assign drop_accept = accept && (in_sel == SEL_DROP);

    slot_reg #(.WIDTH(WORD_WIDTH)) u_slot_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .load_data(in_data),
        .pop_ready(out_ready_a), .valid(out_valid_a), .data(out_data_a), .free(free_a)
    );

    slot_reg #(.WIDTH(WORD_WIDTH)) u_slot_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .load_data(in_data),
        .pop_ready(out_ready_b), .valid(out_valid_b), .data(out_data_b), .free(free_b)
    );

    slot_reg #(.WIDTH(WORD_WIDTH)) u_slot_c (
        .clk(clk), .rst_n(rst_n), .load(load_c), .load_data(in_data),
        .pop_ready(out_ready_c), .valid(out_valid_c), .data(out_data_c), .free(free_c)
    );

    // The counter sticks at all-ones while drop_err keeps pulsing.
    always_comb begin
        drop_err_d   = drop_accept;
        drop_count_d = drop_count_q;
        if (drop_accept && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_err_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_err_q   <= drop_err_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_err   = drop_err_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux3_buf.sv
// Self-checking bench for demux3_buf: directed vector table, hand-written
// saturation/reset sequences, then randomized traffic against a slot model.
module tb_demux3_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic        out_ready_a, out_ready_b, out_ready_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic        drop_err;
    logic [7:0]  drop_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    demux3_buf dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid_a(out_valid_a), .out_valid_b(out_valid_b), .out_valid_c(out_valid_c),
        .out_ready_a(out_ready_a), .out_ready_b(out_ready_b), .out_ready_c(out_ready_c),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_data_c(out_data_c),
        .drop_err(drop_err), .drop_count(drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [2:0] rdy);
        in_valid    = v;
        in_sel      = s;
        in_data     = d;
        out_ready_a = rdy[0];
        out_ready_b = rdy[1];
        out_ready_c = rdy[2];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] val,
                              input logic [31:0] da, input logic [31:0] db,
                              input logic [31:0] dc, input logic err, input logic [7:0] cnt);
        check({tag, " valid"}, {29'd0, out_valid_c, out_valid_b, out_valid_a}, {29'd0, val});
        check({tag, " data_a"}, out_data_a, da);
        check({tag, " data_b"}, out_data_b, db);
        check({tag, " data_c"}, out_data_c, dc);
        check({tag, " drop_err"}, {31'd0, drop_err}, {31'd0, err});
        check({tag, " drop_count"}, {24'd0, drop_count}, {24'd0, cnt});
    endtask

    typedef struct packed {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [2:0]  rdy;      // {c,b,a}
        logic        exp_rdy;  // in_ready before the edge
        logic [2:0]  exp_val;  // {c,b,a} after the edge
        logic [31:0] da, db, dc;
        logic        err;
        logic [7:0]  cnt;
    } vec_t;

    function automatic vec_t mk(logic v, logic [1:0] s, logic [31:0] d, logic [2:0] rdy,
                                logic er, logic [2:0] ev, logic [31:0] da,
                                logic [31:0] db, logic [31:0] dc, logic err, logic [7:0] cnt);
        vec_t t;
        t = '{v, s, d, rdy, er, ev, da, db, dc, err, cnt};
        return t;
    endfunction

    vec_t tbl[17];

    // Randomized-phase model: words held per slot, last word loaded per slot.
    int          m_held[3];
    logic [31:0] m_last[3];
    int          m_drops;
    logic        m_err;

    function automatic logic model_ready(logic [1:0] s, logic [2:0] rdy);
        if (s == 2'd3) return 1'b1;
        return (m_held[s] == 0) || rdy[s];
    endfunction

    initial begin
        drive(1'b1, 2'd0, 32'h1234, 3'b000);
        rst_n = 1'b0;

        // Reset held two edges with a word offered to A.
        for (int i = 0; i < 2; i++) begin
            tick();
            check_outs($sformatf("reset%0d", i), 3'b000, 0, 0, 0, 1'b0, 8'd0);
        end
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 3'b000);
        #1 check("reset in_ready", {31'd0, in_ready}, 32'd1);

        //                v    sel    data       rdy     er    val     da     db     dc   err cnt
        tbl[0]  = mk(1'b1, 2'd1, 32'hA0,   3'b010, 1'b1, 3'b010, 32'h0,  32'hA0, 32'h0,  1'b0, 8'd0);
        tbl[1]  = mk(1'b1, 2'd1, 32'hA1,   3'b010, 1'b1, 3'b010, 32'h0,  32'hA1, 32'h0,  1'b0, 8'd0);
        tbl[2]  = mk(1'b1, 2'd1, 32'hA2,   3'b010, 1'b1, 3'b010, 32'h0,  32'hA2, 32'h0,  1'b0, 8'd0);
        tbl[3]  = mk(1'b1, 2'd1, 32'hA3,   3'b010, 1'b1, 3'b010, 32'h0,  32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[4]  = mk(1'b0, 2'd1, 32'h0,    3'b010, 1'b1, 3'b000, 32'h0,  32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[5]  = mk(1'b1, 2'd0, 32'h11,   3'b000, 1'b1, 3'b001, 32'h11, 32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[6]  = mk(1'b1, 2'd0, 32'h22,   3'b000, 1'b0, 3'b001, 32'h11, 32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[7]  = mk(1'b1, 2'd0, 32'h22,   3'b001, 1'b1, 3'b001, 32'h22, 32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[8]  = mk(1'b0, 2'd0, 32'h0,    3'b001, 1'b1, 3'b000, 32'h22, 32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[9]  = mk(1'b1, 2'd0, 32'h55,   3'b000, 1'b1, 3'b001, 32'h55, 32'hA3, 32'h0,  1'b0, 8'd0);
        tbl[10] = mk(1'b1, 2'd2, 32'h66,   3'b000, 1'b1, 3'b101, 32'h55, 32'hA3, 32'h66, 1'b0, 8'd0);
        tbl[11] = mk(1'b1, 2'd0, 32'h77,   3'b000, 1'b0, 3'b101, 32'h55, 32'hA3, 32'h66, 1'b0, 8'd0);
        tbl[12] = mk(1'b0, 2'd0, 32'h0,    3'b101, 1'b1, 3'b000, 32'h55, 32'hA3, 32'h66, 1'b0, 8'd0);
        tbl[13] = mk(1'b1, 2'd3, 32'hDEAD, 3'b000, 1'b1, 3'b000, 32'h55, 32'hA3, 32'h66, 1'b1, 8'd1);
        tbl[14] = mk(1'b1, 2'd3, 32'hDEAD, 3'b000, 1'b1, 3'b000, 32'h55, 32'hA3, 32'h66, 1'b1, 8'd2);
        tbl[15] = mk(1'b1, 2'd3, 32'hDEAD, 3'b000, 1'b1, 3'b000, 32'h55, 32'hA3, 32'h66, 1'b1, 8'd3);
        tbl[16] = mk(1'b0, 2'd3, 32'h0,    3'b000, 1'b1, 3'b000, 32'h55, 32'hA3, 32'h66, 1'b0, 8'd3);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy);
            #1 check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].exp_val, tbl[i].da, tbl[i].db,
                       tbl[i].dc, tbl[i].err, tbl[i].cnt);
        end

        // Saturation: 252 more drops reach 255, one more stays at 255.
        drive(1'b1, 2'd3, 32'hDEAD, 3'b000);
        repeat (252) tick();
        check("sat count 255", {24'd0, drop_count}, 32'd255);
        #1 check("sat in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("sat count held", {24'd0, drop_count}, 32'd255);
        check("sat drop_err", {31'd0, drop_err}, 32'd1);

        // Reset mid-operation: fill all three, stall a word to A, then reset.
        drive(1'b1, 2'd0, 32'hC0, 3'b000); tick();
        drive(1'b1, 2'd1, 32'hC1, 3'b000); tick();
        drive(1'b1, 2'd2, 32'hC2, 3'b000); tick();
        check_outs("full", 3'b111, 32'hC0, 32'hC1, 32'hC2, 1'b0, 8'd255);
        drive(1'b1, 2'd0, 32'h99, 3'b000);
        #1 check("stall in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check_outs("mid reset", 3'b000, 0, 0, 0, 1'b0, 8'd0);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 3'b000);
        tick();
        check_outs("post reset", 3'b000, 0, 0, 0, 1'b0, 8'd0);

        // Randomized traffic against the model; DUT is empty here.
        for (int k = 0; k < 3; k++) begin
            m_held[k] = 0;
            m_last[k] = 32'h0;
        end
        m_drops = 0;
        m_err   = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        v;
            logic [1:0]  s;
            logic [31:0] d;
            logic [2:0]  rdy;
            logic        exp_rdy;
            v   = ($urandom_range(0, 3) != 0);
            s   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            d   = $urandom;
            rdy = 3'($urandom);
            drive(v, s, d, rdy);
            exp_rdy = model_ready(s, rdy);
            #1 check("rand in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int k = 0; k < 3; k++) begin
                if (m_held[k] > 0 && rdy[k]) m_held[k]--;
            end
            m_err = 1'b0;
            if (v && exp_rdy) begin
                if (s == 2'd3) begin
                    m_err = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_held[s]++;
                    m_last[s] = d;
                end
            end
            tick();
            check_outs("rand", {m_held[2] > 0, m_held[1] > 0, m_held[0] > 0},
                       m_last[0], m_last[1], m_last[2], m_err, 8'(m_drops));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux3_buf.md
# demux3_buf

Registered 1-to-3 demultiplexer with per-destination valid/ready handshakes. It is the distribution-side counterpart to the datapath source-select muxes. It takes one producer stream (word plus 2-bit destination select) and steers each word into one of three one-entry output buffers, e.g. GPR write-back, HI/LO, CP0. An invalid select (2'b11) is consumed and dropped, and the drop is flagged and counted.

## Interface
- WORD_WIDTH, `WORD_WIDTH (32): data width of input and all outputs
- SEL_WIDTH, 2: destination select width; fixed at 2
- CNT_WIDTH, 8: width of saturating drop counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has a word
- in_ready  output  1  word accepted this cycle when in_valid & in_ready
- in_data  input  WORD_WIDTH  producer word
- in_sel  input  SEL_WIDTH  destination: 00→A, 01→B, 10→C, 11→drop
- out_valid_a / out_valid_b / out_valid_c  output  1 each  buffer holds a word
- out_ready_a / out_ready_b / out_ready_c  input  1 each  consumer takes word
- out_data_a / out_data_b / out_data_c  output  WORD_WIDTH each  buffered word
- drop_err  output  1  one-cycle pulse after a select-11 word is accepted
- drop_count  output  CNT_WIDTH  number of dropped words, saturating

## Operation
- Per destination X ∈ {A,B,C}: one register slot {valid_x, data_x}.
- Pop_x = out_valid_x & out_ready_x.
- Free_x = ~valid_x | pop_x. This gives same-cycle drain-and-refill, i.e. full throughput per destination.
- in_ready = Free of the slot addressed by in_sel. For in_sel=11, in_ready=1. Combinational from in_sel, valid_x and out_ready_x, with no path from in_data.
- Accept = in_valid & in_ready. On accept to X: data_x ← in_data and valid_x ← 1.
- Otherwise, if pop_x: valid_x ← 0, and data_x holds its last value.
- Slots are independent. A full, stalled slot blocks only words addressed to it: head-of-line blocking on the single input, no reordering.
- On accept with in_sel=11: no slot changes, drop_err ← 1 next cycle, drop_count ← drop_count+1 unless all-ones.
- drop_err ← 0 in every cycle with no such accept.
- When in_valid=0, in_sel and in_data are don't-care, with no state change. in_ready is still driven.
- out_data_x is meaningful only while out_valid_x=1. Once valid, data_x is stable until popped.

## Timing
- Reset, checked at the rising edge with rst_n=0:
  - all out_valid_x=0, all out_data_x=0
  - drop_err=0, drop_count=0
  - in_ready then reflects the empty slots, so it is 1.
- Reset mid-transfer discards buffered words. Nothing accepted in the reset cycle is stored.
- Latency: a word accepted at edge N appears on out_valid_x/out_data_x after edge N.
- The earliest pop is at edge N+1.
- Throughput: 1 word/cycle into any single destination when its consumer holds ready=1.
- Simultaneous pop and accept on the same slot: valid stays 1 and data takes the new word.
- Simultaneous pops on several slots: all occur.
- drop_count saturates at 2^CNT_WIDTH−1, and drop_err still pulses at saturation.

## Structure
- Select encodings (SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_DROP=2'b11) go in the shared constants header next to `WORD_WIDTH.
- One sub-module is natural, instantiated three times: `slot_reg`.
  - Inputs: clk, rst_n, load, load_data, pop_ready.
  - Outputs: valid, data, free.
- The top level holds select decode, the in_ready mux, and drop logic.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, in_sel=00, in_data=0x1234 → all out_valid=0, out_data=0, drop_count=0; after release, in_ready=1.
- Stream to B: send 0xA0..0xA3 back-to-back with out_ready_b=1 → in_ready stays 1, and out_data_b shows 0xA0..0xA3 on consecutive cycles, each one cycle after accept.
- Backpressure: out_ready_a=0, send 0x11 to A, then 0x22 to A → 0x22 stalls (in_ready=0) while out_valid_a=1 with 0x11. Raise out_ready_a → 0x22 accepted that same cycle, and out_data_a=0x22 next cycle.
- Independence: A full and stalled (0x55), then send 0x66 to C → accepted immediately, out_valid_c=1 with 0x66 next cycle, and A keeps 0x55.
- Drop: send 0xDEAD with in_sel=11 three times → in_ready=1 each time, drop_err pulses 3 cycles, drop_count=3, no out_valid asserted. Preload drop_count to 255 via 255 drops, drop once more → count stays 255 and drop_err=1.
- Reset mid-operation: A, B, C all full, assert rst_n=0 for one edge → all out_valid=0 and drop_count=0 the next cycle; the stalled input word is not stored.
